// File: rtl/sap2_fetch_if.sv
// sap2_fetch_if: fetch-side bundle between the SAP-2 fetch sequencer, the memory stage, execute and the decoder.
// Ports: mem_grant, mem_out, pc_load, pc_in, instr_ready (into fetch);
//        mar_loadh, mar_loadl, ram_enl, bus_out, bus_en, pc, opcode, operand, instr_len, instr_valid, halted (out of fetch).
interface sap2_fetch_if;
  logic        mem_grant;
  logic [15:0] mem_out;
  logic        pc_load;
  logic [15:0] pc_in;
  logic        instr_ready;
  logic        mar_loadh;
  logic        mar_loadl;
  logic        ram_enl;
  logic [15:0] bus_out;
  logic        bus_en;
  logic [15:0] pc;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic [1:0]  instr_len;
  logic        instr_valid;
  logic        halted;
  modport master (
    input  mem_grant, mem_out, pc_load, pc_in, instr_ready,
    output mar_loadh, mar_loadl, ram_enl, bus_out, bus_en, pc, opcode, operand, instr_len, instr_valid, halted
  );
  modport slave (
    output mem_grant, mem_out, pc_load, pc_in, instr_ready,
    input  mar_loadh, mar_loadl, ram_enl, bus_out, bus_en, pc, opcode, operand, instr_len, instr_valid, halted
  );
endinterface

// File: rtl/sap2_fetch.sv
// sap2_fetch: SAP-2 instruction fetch sequencer; owns pc, drives MAR/RAM strobes, assembles 1-3 byte instructions for the decoder.
// Ports: clk, rst (sync, active-high), f (sap2_fetch_if.master). Parameter RESET_PC. Define FETCH_PREFETCH_EN to overlap the next MAR load with CAPTURE.
module sap2_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic        clk,
  input logic        rst,
  sap2_fetch_if.master f
);
  localparam logic [2:0] ADDR = 3'd0, READ = 3'd1, CAPTURE = 3'd2, HOLD = 3'd3, HALT = 3'd4;
  logic [2:0] state;
  logic [1:0] idx;
  logic [7:0] b;
  logic [1:0] len_b;
  logic       last;
  logic       pre;
  logic       load_mar;
  assign b = f.mem_out[7:0];
  assign len_b = (b inside {8'hC2, 8'hC3, 8'hCA, 8'hCD, 8'hFA, 8'h32, 8'h3A}) ? 2'd3 :
                 (b inside {8'h06, 8'h0E, 8'h3E, 8'hD3, 8'hDB, 8'hE6, 8'hEE, 8'hF6}) ? 2'd2 : 2'd1;
  // byte 0 decides from the live opcode; later bytes from the latched length
  assign last = (idx == 2'd0) ? (len_b == 2'd1) : (idx == 2'd1) ? (f.instr_len == 2'd2) : 1'b1;
`ifdef FETCH_PREFETCH_EN
  assign pre = (state == CAPTURE) && !last && f.mem_grant;
`else
  assign pre = 1'b0;
`endif
  assign load_mar = !rst && ((state == ADDR && f.mem_grant) || pre);
  assign f.mar_loadh = load_mar;
  assign f.mar_loadl = load_mar;
  assign f.bus_en = load_mar;
  assign f.bus_out = !load_mar ? 16'h0000 : pre ? f.pc + 16'h0001 : f.pc;
  assign f.ram_enl = !rst && state == READ && f.mem_grant;
  assign f.instr_valid = !rst && state == HOLD;
  assign f.halted = !rst && state == HALT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ADDR;
      idx <= 2'd0;
      f.pc <= RESET_PC;
      f.opcode <= 8'h00;
      f.operand <= 16'h0000;
      f.instr_len <= 2'd0;
    end else if (f.pc_load) begin
      state <= ADDR;
      idx <= 2'd0;
      f.pc <= f.pc_in;
    end else begin
      case (state)
        ADDR: state <= f.mem_grant ? READ : ADDR;
        // losing the grant mid-read means MAR may hold someone else's address
        READ: state <= f.mem_grant ? CAPTURE : ADDR;
        CAPTURE: begin
          f.pc <= f.pc + 16'h0001;
          idx <= last ? 2'd0 : idx + 2'd1;
          if (idx == 2'd0) begin
            f.opcode <= b;
            f.instr_len <= len_b;
            f.operand <= 16'h0000;
          end else if (idx == 2'd1) begin
            f.operand[7:0] <= b;
          end else begin
            f.operand[15:8] <= b;
          end
          state <= last ? HOLD : pre ? READ : ADDR;
        end
        HOLD: if (f.instr_ready) state <= (f.opcode == 8'h76) ? HALT : ADDR;
        HALT: state <= HALT;
        default: state <= ADDR;
      endcase
    end
  end
endmodule

// File: tb/tb_sap2_fetch.sv
// tb_sap2_fetch: directed self-checking bench for sap2_fetch with a byte-wide RAM/MAR/MDR model.
module tb_sap2_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sap2_fetch_if bus ();
  sap2_fetch dut (.clk(clk), .rst(rst), .f(bus));
  logic [7:0]  ram [0:65535];
  logic [15:0] mar;
  logic [7:0]  mdr;
  always @(posedge clk) begin
    if (bus.mar_loadl) mar <= bus.bus_out;
    if (bus.ram_enl) mdr <= ram[mar];
  end
  assign bus.mem_out = {8'hEE, mdr};
  int checks = 0;
  int failures = 0;
`ifdef FETCH_PREFETCH_EN
  localparam int V1 = 3, V2 = 5, V3 = 7;
`else
  localparam int V1 = 3, V2 = 6, V3 = 9;
`endif

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.instr_valid && cyc < 40) begin
      step();
      cyc++;
    end
    checks++;
    if (!bus.instr_valid) begin
      failures++;
      $display("FAIL wait_valid timeout: instr_valid=%b after %0d cycles, required 1", bus.instr_valid, cyc);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.mem_grant = 1'b1;
    bus.instr_ready = 1'b0;
    bus.pc_load = 1'b1;
    bus.pc_in = 16'h7777;
    step();
    step();
    checks++;
    if (bus.pc !== 16'h0000) begin failures++; $display("FAIL reset_pc: got %h required 0000", bus.pc); end
    checks++;
    if ({bus.mar_loadh, bus.mar_loadl, bus.bus_en, bus.ram_enl} !== 4'b0) begin failures++; $display("FAIL reset_strobes: got %b required 0000", {bus.mar_loadh, bus.mar_loadl, bus.bus_en, bus.ram_enl}); end
    checks++;
    if ({bus.bus_out, bus.opcode, bus.operand, bus.instr_len} !== 42'h0) begin failures++; $display("FAIL reset_regs: got %h required 0", {bus.bus_out, bus.opcode, bus.operand, bus.instr_len}); end
    checks++;
    if ({bus.instr_valid, bus.halted} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b required 00", {bus.instr_valid, bus.halted}); end
    bus.pc_load = 1'b0;
  endtask

  task automatic test_two_byte;
    int c;
    ram[0] = 8'h3E;
    ram[1] = 8'h55;
    bus.instr_ready = 1'b0;
    do_reset();
    checks++;
    if ({bus.bus_en, bus.mar_loadh, bus.mar_loadl, bus.bus_out} !== {3'b111, 16'h0000}) begin failures++; $display("FAIL cycle0_addr: got %b/%h required 111/0000", {bus.bus_en, bus.mar_loadh, bus.mar_loadl}, bus.bus_out); end
    wait_valid(c);
    checks++;
    if (c !== V2) begin failures++; $display("FAIL two_byte_latency: got %0d required %0d", c, V2); end
    checks++;
    if ({bus.opcode, bus.operand, bus.instr_len, bus.pc} !== {8'h3E, 16'h0055, 2'd2, 16'h0002}) begin failures++; $display("FAIL two_byte_fields: got %h %h %0d %h required 3e 0055 2 0002", bus.opcode, bus.operand, bus.instr_len, bus.pc); end
  endtask

  task automatic test_three_byte_redirect;
    int c;
    ram[0] = 8'hC3;
    ram[1] = 8'h34;
    ram[2] = 8'h12;
    bus.instr_ready = 1'b0;
    do_reset();
    wait_valid(c);
    checks++;
    if (c !== V3) begin failures++; $display("FAIL three_byte_latency: got %0d required %0d", c, V3); end
    checks++;
    if ({bus.opcode, bus.operand, bus.instr_len, bus.pc} !== {8'hC3, 16'h1234, 2'd3, 16'h0003}) begin failures++; $display("FAIL three_byte_fields: got %h %h %0d %h required c3 1234 3 0003", bus.opcode, bus.operand, bus.instr_len, bus.pc); end
    bus.instr_ready = 1'b1;
    bus.pc_load = 1'b1;
    bus.pc_in = 16'h1234;
    step();
    bus.instr_ready = 1'b0;
    bus.pc_load = 1'b0;
    #1;
    checks++;
    if ({bus.bus_en, bus.bus_out, bus.instr_valid} !== {1'b1, 16'h1234, 1'b0}) begin failures++; $display("FAIL redirect_addr: got en=%b bus=%h valid=%b required 1 1234 0", bus.bus_en, bus.bus_out, bus.instr_valid); end
  endtask

  task automatic test_hold_stall;
    int c;
    ram[16'h1234] = 8'h00;
    wait_valid(c);
    checks++;
    if (c !== V1) begin failures++; $display("FAIL one_byte_latency: got %0d required %0d", c, V1); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.instr_valid, bus.opcode, bus.operand, bus.instr_len, bus.pc, bus.bus_en, bus.ram_enl, bus.mar_loadh} !== {1'b1, 8'h00, 16'h0000, 2'd1, 16'h1235, 3'b000}) begin
        failures++;
        $display("FAIL hold_stable[%0d]: got v=%b op=%h opnd=%h len=%0d pc=%h str=%b required 1 00 0000 1 1235 000", i, bus.instr_valid, bus.opcode, bus.operand, bus.instr_len, bus.pc, {bus.bus_en, bus.ram_enl, bus.mar_loadh});
      end
      step();
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    #1;
    checks++;
    if ({bus.bus_en, bus.bus_out, bus.instr_valid} !== {1'b1, 16'h1235, 1'b0}) begin failures++; $display("FAIL hold_resume: got en=%b bus=%h valid=%b required 1 1235 0", bus.bus_en, bus.bus_out, bus.instr_valid); end
  endtask

  task automatic test_grant_drop;
    int c;
    ram[0] = 8'h3E;
    ram[1] = 8'hA5;
    bus.instr_ready = 1'b0;
    do_reset();
    c = 0;
    while (bus.pc !== 16'h0001 && c < 20) begin step(); c++; end
`ifndef FETCH_PREFETCH_EN
    step();
`endif
    bus.mem_grant = 1'b0;
    #1;
    checks++;
    if (bus.ram_enl !== 1'b0) begin failures++; $display("FAIL grant_drop_read: ram_enl got %b required 0", bus.ram_enl); end
    step();
    bus.mem_grant = 1'b1;
    #1;
    checks++;
    if ({bus.bus_en, bus.bus_out} !== {1'b1, 16'h0001}) begin failures++; $display("FAIL grant_drop_redrive: got en=%b bus=%h required 1 0001", bus.bus_en, bus.bus_out); end
    wait_valid(c);
    checks++;
    if ({bus.operand, bus.pc} !== {16'h00A5, 16'h0002}) begin failures++; $display("FAIL grant_drop_operand: got %h pc=%h required 00a5 0002", bus.operand, bus.pc); end
  endtask

  task automatic test_back_to_back;
    int c;
    ram[0] = 8'h80;
    ram[1] = 8'h3C;
    bus.instr_ready = 1'b1;
    do_reset();
    wait_valid(c);
    checks++;
    if ({c, bus.opcode} !== {V1, 8'h80}) begin failures++; $display("FAIL b2b_first: got cyc=%0d op=%h required %0d 80", c, bus.opcode, V1); end
    step();
    checks++;
    if ({bus.bus_en, bus.bus_out} !== {1'b1, 16'h0001}) begin failures++; $display("FAIL b2b_next_addr: got en=%b bus=%h required 1 0001", bus.bus_en, bus.bus_out); end
    wait_valid(c);
    checks++;
    if ({c, bus.opcode, bus.instr_len} !== {V1, 8'h3C, 2'd1}) begin failures++; $display("FAIL b2b_second: got cyc=%0d op=%h len=%0d required %0d 3c 1", c, bus.opcode, bus.instr_len, V1); end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_halt;
    int c;
    logic bad;
    ram[0] = 8'h76;
    ram[16'h0010] = 8'h80;
    bus.instr_ready = 1'b1;
    do_reset();
    wait_valid(c);
    checks++;
    if (bus.opcode !== 8'h76) begin failures++; $display("FAIL halt_opcode: got %h required 76", bus.opcode); end
    step();
    checks++;
    if ({bus.halted, bus.instr_valid} !== 2'b10) begin failures++; $display("FAIL halt_entry: got halted=%b valid=%b required 1 0", bus.halted, bus.instr_valid); end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ({bus.halted, bus.bus_en, bus.mar_loadh, bus.mar_loadl, bus.ram_enl} !== 5'b10000) bad = 1'b1;
      step();
    end
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL halt_quiet: strobes or halted changed over 20 cycles, got bad=%b required 0", bad); end
    bus.pc_load = 1'b1;
    bus.pc_in = 16'h0010;
    step();
    bus.pc_load = 1'b0;
    #1;
    checks++;
    if ({bus.halted, bus.bus_en, bus.bus_out} !== {2'b01, 16'h0010}) begin failures++; $display("FAIL halt_resume: got halted=%b en=%b bus=%h required 0 1 0010", bus.halted, bus.bus_en, bus.bus_out); end
    wait_valid(c);
    checks++;
    if ({bus.opcode, bus.pc} !== {8'h80, 16'h0011}) begin failures++; $display("FAIL halt_resume_fetch: got op=%h pc=%h required 80 0011", bus.opcode, bus.pc); end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_wrap_and_reset;
    int c;
    ram[16'hFFFF] = 8'h80;
    bus.instr_ready = 1'b0;
    bus.pc_load = 1'b1;
    bus.pc_in = 16'hFFFF;
    step();
    bus.pc_load = 1'b0;
    wait_valid(c);
    checks++;
    if ({bus.opcode, bus.instr_len, bus.pc} !== {8'h80, 2'd1, 16'h0000}) begin failures++; $display("FAIL pc_wrap: got op=%h len=%0d pc=%h required 80 1 0000", bus.opcode, bus.instr_len, bus.pc); end
    bus.pc_load = 1'b1;
    bus.pc_in = 16'h0042;
    step();
    bus.pc_load = 1'b0;
    step();
    checks++;
    if (bus.ram_enl !== 1'b1) begin failures++; $display("FAIL mid_read: ram_enl got %b required 1", bus.ram_enl); end
    rst = 1'b1;
    bus.pc_load = 1'b1;
    bus.pc_in = 16'h7777;
    step();
    checks++;
    if (bus.pc !== 16'h0000) begin failures++; $display("FAIL midread_reset_pc: got %h required 0000", bus.pc); end
    checks++;
    if ({bus.mar_loadh, bus.mar_loadl, bus.bus_en, bus.ram_enl, bus.instr_valid, bus.halted, bus.bus_out, bus.opcode, bus.operand, bus.instr_len} !== 48'h0) begin
      failures++;
      $display("FAIL midread_reset_outputs: got str=%b bus=%h op=%h opnd=%h len=%0d required all 0", {bus.mar_loadh, bus.mar_loadl, bus.bus_en, bus.ram_enl, bus.instr_valid, bus.halted}, bus.bus_out, bus.opcode, bus.operand, bus.instr_len);
    end
    bus.pc_load = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    test_reset();
    test_two_byte();
    test_three_byte_redirect();
    test_hold_stall();
    test_grant_drop();
    test_back_to_back();
    test_halt();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
